// File: rtl/debounce_arr.sv
// debounce_arr: per-channel two-flop synchroniser followed by a tick-sampled
// stability filter; all channels share one sample-rate prescaler.
module debounce_arr #(
  parameter int WIDTH      = 18,
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic             tick
);

  localparam int              PC_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SAMPLE_DIV - 1);
  localparam logic [3:0]      CNT_LAST = 4'(STABLE_CNT - 1);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [WIDTH-1:0] clean_r;
  logic [WIDTH-1:0] clean_nxt_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic             tick_r;
  logic             tick_nxt_s;
  logic [3:0]       cnt_r     [WIDTH];
  logic [3:0]       cnt_nxt_s [WIDTH];

  // Two-stage synchroniser on every raw input bit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
    end
  end

  // Prescaler: tick is raised for the cycle after pc wraps
  always_comb begin
    pc_nxt_s   = pc_r;
    tick_nxt_s = 1'b0;
    if (pc_r == PC_LAST) begin
      pc_nxt_s   = '0;
      tick_nxt_s = 1'b1;
    end else begin
      pc_nxt_s   = pc_r + PC_W'(1);
      tick_nxt_s = 1'b0;
    end
  end

  // Per-channel filter; any sample matching clean throws away the evidence so far
  always_comb begin
    clean_nxt_s = clean_r;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (tick_r) begin
        if (s2_r[i] == clean_r[i]) begin
          cnt_nxt_s[i] = 4'd0;
        end else if (cnt_r[i] == CNT_LAST) begin
          clean_nxt_s[i] = s2_r[i];
          cnt_nxt_s[i]   = 4'd0;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + 4'd1;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // State registers for prescaler, counters and clean levels
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_r    <= '0;
      tick_r  <= 1'b0;
      clean_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= 4'd0;
      end
    end else begin
      pc_r    <= pc_nxt_s;
      tick_r  <= tick_nxt_s;
      clean_r <= clean_nxt_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  assign clean = clean_r;
  assign tick  = tick_r;

endmodule
